wal_product_accum: RTL and testbench
====================================

// Module: wal_product_accum
// PURPOSE
//  Downstream consumer of the pipelined 16x16 Wallace multiplier's 32-bit unsigned products.
//  Sums a group of products (dot-product / MAC use) into a wide saturating accumulator.
//  Presents each group result, term count and overflow flag on a valid/ready output register.
//  The multiplier has no stall, so the integrator gates multiplier issue with prod_ready.
// PARAMETERS
//  PROD_W  32  product width; matches the multiplier output.
//  ACC_W   40  accumulator width; must be >= PROD_W+1.
//  CNT_W    8  term-counter width; the counter saturates at 2^CNT_W-1.
// PORTS
//  clk        in   1       single clock; all state updates on posedge clk.
//  rst        in   1       synchronous, active-high reset.
//  prod_in    in   PROD_W  unsigned product from the multiplier.
//  prod_valid in   1       prod_in is valid this cycle.
//  prod_last  in   1       this beat is the final term of the group.
//  prod_ready out  1       beat is accepted when prod_valid & prod_ready.
//  acc_out    out  ACC_W   group sum; saturated on overflow.
//  cnt_out    out  CNT_W   number of terms in the group; saturating.
//  ovf_out    out  1       the group overflowed ACC_W.
//  out_valid  out  1       acc_out, cnt_out and ovf_out are valid.
//  out_ready  in   1       consumer accepts the output when out_valid & out_ready.
// BEHAVIOUR
//  Reset (rst=1 at posedge): acc=0, cnt=0, ovf=0, state=IDLE, out_valid=0, acc_out=0,
//   cnt_out=0, ovf_out=0. Reset has priority over every other event.
//   A result still pending at reset is dropped. A partial group is discarded.
//  prod_ready = !out_valid | out_ready (combinational). The same rule applies to last and
//   non-last beats.
//  State machine:
//   IDLE  - no terms held. An accepted beat loads acc=prod_in, cnt=1, ovf=0.
//           A non-last beat moves to ACCUM. A last beat emits the result and stays in IDLE.
//   ACCUM - an accepted beat computes sum = acc + prod_in at ACC_W+1 bits.
//           If sum carries out, or ovf is already set: acc = all ones, ovf = 1.
//           Otherwise acc = sum[ACC_W-1:0].
//           cnt increments and stops at all ones. A last beat emits and returns to IDLE.
//  Emit: on the posedge that accepts a last beat, the final acc/cnt/ovf values (this beat
//   included) load the output register and out_valid is set.
//   The internal acc/cnt/ovf clear in the same cycle. Latency is 1 cycle from the last beat.
//  Output handshake: an output is accepted on out_valid & out_ready.
//   Without a new emit, out_valid clears on acceptance.
//   If an emit coincides with acceptance, out_valid stays 1 and the output register takes
//   the new result. There are no bubbles between groups.
//  The output register holds stable while out_valid & !out_ready.
//  prod_valid=0 cycles leave all state unchanged. Gaps inside a group are legal.
//  Arithmetic is unsigned only; prod_in is zero-extended to ACC_W.
// STRUCTURE
//  Shared package wal_pkg: PROD_W/ACC_W/CNT_W defaults and the state typedef/encoding
//   {IDLE, ACCUM}. The multiplier stages and this block share it.
//  One sub-module, wal_sat_add: ACC_W + PROD_W adder with carry-out detect and saturation.
//   Purely combinational.
//  Top level: FSM, term counter, output register and handshake logic.
// TESTING
//  1 rst 2 cycles, then beats 1, 2, 3 (last on 3), out_ready=1 -> next cycle out_valid=1,
//    acc_out=40'h00_0000_0006, cnt_out=3, ovf_out=0.
//  2 Single-beat group prod_in=32'hB29C4D63 (b29d*ffff) with last -> acc_out=40'h00B29C4D63,
//    cnt_out=1, ovf_out=0.
//  3 256 beats of 32'hFFFE0001 -> acc_out=40'hFF_FE00_0100, cnt_out=8'hFF, ovf_out=0.
//    257 beats -> acc_out=40'hFF_FFFF_FFFF, ovf_out=1.
//  4 out_ready=0 after group A emits -> prod_ready=0 and group B beats are not taken.
//    acc_out holds A. Raising out_ready -> A accepted, then B completes correctly.
//  5 out_valid=1, out_ready=1 and a last beat accepted in the same cycle -> out_valid stays 1,
//    output register shows the new group, with no lost or duplicated result.
//  6 Beats 5, 7 (non-last), then rst, then beat 9 with last -> acc_out=9, cnt_out=1,
//    ovf_out=0. No earlier output appears.

Source files
------------

// File: rtl/wal_pkg.sv
// Shared definitions for the Wallace multiplier datapath and its product accumulator.
package wal_pkg;

  // Default widths: multiplier product, accumulator, and term counter.
  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  // Accumulator FSM encoding: no terms held vs. partial group in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/wal_sat_add.sv
// Combinational saturating adder: wide accumulator plus zero-extended product.
// A carry out of ACC_W bits, or an already-sticky overflow, forces all ones.
module wal_sat_add
  import wal_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_ovf,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic [ACC_W:0] w_sum;

  // Add at ACC_W+1 bits so the carry out is visible, then saturate.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    o_sum = '0;
    o_ovf = 1'b0;
    w_sum = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    if (w_sum[ACC_W] || i_ovf) begin
      o_sum = '1;
      o_ovf = 1'b1;
    end else begin
      o_sum = w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/wal_product_accum.sv
// Sums groups of unsigned multiplier products into a saturating accumulator and
// presents each group result on a valid/ready output register with no inter-group bubbles.
module wal_product_accum
  import wal_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              ovf_out,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_acc_out;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_ovf_out;
  logic             r_out_valid;

  logic             w_accept;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_nxt_acc;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_nxt_ovf;

  // A new beat can be taken whenever the output slot is empty or is being drained now.
  assign prod_ready = !r_out_valid || out_ready;
  assign w_accept   = prod_valid && prod_ready;

  wal_sat_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_acc (r_acc),
    .i_prod(prod_in),
    .i_ovf (r_ovf),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  // Running totals including the current beat: a fresh load in IDLE, a saturating add in ACCUM.
  always_comb begin
    w_nxt_acc = {{(ACC_W - PROD_W){1'b0}}, prod_in};
    w_nxt_cnt = CNT_W'(1);
    w_nxt_ovf = 1'b0;
    if (r_state == ACCUM) begin
      w_nxt_acc = w_add_sum;
      w_nxt_ovf = w_add_ovf;
      w_nxt_cnt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  // FSM, accumulator, and output register; an emit overrides a same-cycle drain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_acc_out   <= '0;
      r_cnt_out   <= '0;
      r_ovf_out   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (prod_last) begin
          r_acc_out   <= w_nxt_acc;
          r_cnt_out   <= w_nxt_cnt;
          r_ovf_out   <= w_nxt_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
          r_state     <= IDLE;
        end else begin
          r_acc   <= w_nxt_acc;
          r_cnt   <= w_nxt_cnt;
          r_ovf   <= w_nxt_ovf;
          r_state <= ACCUM;
        end
      end
    end
  end

  assign acc_out   = r_acc_out;
  assign cnt_out   = r_cnt_out;
  assign ovf_out   = r_ovf_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_wal_product_accum.sv
// Directed bench for wal_product_accum: a per-cycle vector table plus hand-written
// sequences for saturation, backpressure, back-to-back emits and mid-group reset.
module tb_wal_product_accum;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  cnt_out;
  logic              ovf_out;
  logic              out_valid;
  logic              out_ready;

  int tests_run = 0;
  int tests_failed = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  wal_product_accum #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_last (prod_last),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .cnt_out   (cnt_out),
    .ovf_out   (ovf_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Count output handshakes to catch lost or duplicated results.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic        valid;
    logic        last;
    logic [31:0] prod;
    logic        ordy;
    logic        exp_valid;
    logic [39:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic l, input logic [31:0] p, input logic r);
    prod_valid = v;
    prod_last  = l;
    prod_in    = p;
    out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [39:0] a, input logic [7:0] c,
                           input logic o);
    check({name, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({name, ".acc"}, {24'd0, acc_out}, {24'd0, a});
    check({name, ".cnt"}, {56'd0, cnt_out}, {56'd0, c});
    check({name, ".ovf"}, {63'd0, ovf_out}, {63'd0, o});
  endtask

  vec_t vecs[12];
  int   hs0;

  initial begin
    // Group 1,2,3 then single-beat B29C4D63 issued while draining the first result.
    vecs[0]  = '{1'b1, 1'b0, 32'd1,          1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd2,          1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'd3,          1'b1, 1'b1, 40'h00_0000_0006,  8'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'hB29C4D63,   1'b1, 1'b1, 40'h00_B29C_4D63,  8'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    // Gap inside a group: 10, idle, 20.
    vecs[5]  = '{1'b1, 1'b0, 32'd10,         1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'd99,         1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'd20,         1'b1, 1'b1, 40'd30,            8'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    // Carry out of 32 bits is not an accumulator overflow.
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   1'b1, 1'b0, 40'd0,             8'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'hFFFFFFFF,   1'b1, 1'b1, 40'h01_FFFF_FFFE,  8'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'd0,          1'b1, 1'b0, 40'd0,             8'd0, 1'b0};

    rst = 1'b1;
    prod_valid = 1'b0;
    prod_last = 1'b0;
    prod_in = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", {63'd0, out_valid}, 64'd0);
    check("reset.acc", {24'd0, acc_out}, 64'd0);
    check("reset.cnt", {56'd0, cnt_out}, 64'd0);
    check("reset.ovf", {63'd0, ovf_out}, 64'd0);
    check("reset.pready", {63'd0, prod_ready}, 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].valid, vecs[i].last, vecs[i].prod, vecs[i].ordy);
      check($sformatf("vec%0d.valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.acc", i), {24'd0, acc_out}, {24'd0, vecs[i].exp_acc});
        check($sformatf("vec%0d.cnt", i), {56'd0, cnt_out}, {56'd0, vecs[i].exp_cnt});
        check($sformatf("vec%0d.ovf", i), {63'd0, ovf_out}, {63'd0, vecs[i].exp_ovf});
      end
    end

    // 256 beats: exact fit, counter saturates at 255.
    for (int i = 0; i < 256; i++) cyc(1'b1, (i == 255), 32'hFFFE0001, 1'b1);
    check_out("sat256", 40'hFF_FE00_0100, 8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // 257 beats overflow, then a zero beat: overflow must stay sticky.
    for (int i = 0; i < 257; i++) cyc(1'b1, 1'b0, 32'hFFFE0001, 1'b1);
    cyc(1'b1, 1'b1, 32'd0, 1'b1);
    check_out("sat258", 40'hFF_FFFF_FFFF, 8'hFF, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // Backpressure: result A held, group B beats refused until drained.
    cyc(1'b1, 1'b1, 32'd4, 1'b0);
    check_out("bpA", 40'd4, 8'd1, 1'b0);
    prod_valid = 1'b1;
    prod_last = 1'b0;
    prod_in = 32'd100;
    #1;
    check("bp.pready", {63'd0, prod_ready}, 64'd0);
    cyc(1'b1, 1'b0, 32'd100, 1'b0);
    cyc(1'b1, 1'b0, 32'd100, 1'b0);
    check_out("bpHold", 40'd4, 8'd1, 1'b0);
    cyc(1'b1, 1'b0, 32'd100, 1'b1);
    check("bpDrain.valid", {63'd0, out_valid}, 64'd0);
    cyc(1'b1, 1'b1, 32'd200, 1'b1);
    check_out("bpB", 40'd300, 8'd2, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // Emit coinciding with acceptance: no bubble, exactly two handshakes.
    hs0 = hs_cnt;
    cyc(1'b1, 1'b1, 32'd7, 1'b0);
    check_out("b2bC", 40'd7, 8'd1, 1'b0);
    cyc(1'b1, 1'b1, 32'd8, 1'b1);
    check_out("b2bD", 40'd8, 8'd1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    check("b2b.drain", {63'd0, out_valid}, 64'd0);
    check("b2b.hs", 64'(hs_cnt - hs0), 64'd2);

    // Mid-group reset discards the partial group 5+7.
    cyc(1'b1, 1'b0, 32'd5, 1'b1);
    cyc(1'b1, 1'b0, 32'd7, 1'b1);
    check("rstmid.pre", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    check("rstmid.valid", {63'd0, out_valid}, 64'd0);
    cyc(1'b1, 1'b1, 32'd9, 1'b1);
    check_out("rstmid", 40'd9, 8'd1, 1'b0);

    // Reset drops a pending result.
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    check("rstdrop.valid", {63'd0, out_valid}, 64'd0);
    check("rstdrop.acc", {24'd0, acc_out}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
